// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) that runs entirely on clk.
// sclk, ss_n and mosi are oversampled through synchronizers, so sclk clocks no flops.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   sclk, ss_n, mosi    SPI inputs from the master (asynchronous to clk)
//   miso, miso_oe       serial data out and its tri-state enable
//   tx_data/tx_valid/tx_ready   single-entry transmit buffer, valid/ready handshake
//   rx_data/rx_valid    last complete received word and its one-cycle strobe
//   busy                select active (synchronized ss_n low)
//   tx_underrun         one-cycle strobe: FILL was loaded because the buffer was empty
module spi_slave_sync #(
    parameter int unsigned     BITS = 8,
    parameter logic [BITS-1:0] FILL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sclk,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            tx_underrun
);

    localparam int unsigned CNT_W = $clog2(BITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizer chains: bit 0 = s1, bit 1 = s2, bit 2 = s3.
    // mosi is only ever read from its second stage, so its chain stops there.
    logic [2:0]      sclk_sync_q, sclk_sync_d;
    logic [2:0]      ss_sync_q, ss_sync_d;
    logic [1:0]      mosi_sync_q, mosi_sync_d;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic            word_end_q, word_end_d;
    logic [BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BITS-1:0] tx_buf_q, tx_buf_d;
    logic            tx_ready_q, tx_ready_d;
    logic [BITS-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            busy_q, busy_d;
    logic            miso_q, miso_d;
    logic            miso_oe_q, miso_oe_d;
    logic            tx_underrun_q, tx_underrun_d;

    logic            sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s2, load;

    // Next-state logic: edge detection, FSM, shifters and transmit buffer.
    always_comb begin
        sclk_sync_d   = {sclk_sync_q[1:0], sclk};
        ss_sync_d     = {ss_sync_q[1:0], ss_n};
        mosi_sync_d   = {mosi_sync_q[0], mosi};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_end_d    = word_end_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_ready_d    = tx_ready_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        load          = 1'b0;

        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
        ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
        ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
        mosi_s2   = mosi_sync_q[1];

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    load      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ACTIVE: begin
                // Deselect has priority over any coincident sclk edge.
                if (ss_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    word_end_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[BITS-2:0], mosi_s2};
                    if (bit_cnt_q == CNT_W'(BITS - 1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        word_end_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall after a word's last bit presents the next word's MSB.
                    if (word_end_q) begin
                        load       = 1'b1;
                        word_end_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load uses the buffer state before any same-cycle write.
        if (load) begin
            if (!tx_ready_q) begin
                tx_shift_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = FILL;
                tx_underrun_d = 1'b1;
            end
        end

        if (tx_valid && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        busy_d    = (state_d == ACTIVE);
        miso_oe_d = busy_d;
        miso_d    = busy_d & tx_shift_d[BITS-1];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q   <= 3'b000;
            ss_sync_q     <= 3'b111;
            mosi_sync_q   <= 2'b00;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            word_end_q    <= 1'b0;
            tx_shift_q    <= FILL;
            rx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_end_q    <= word_end_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural mode-0 master drives the link,
// while monitors log rx_valid words and tx_underrun pulses for checking.
module tb_spi_slave_sync;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;

    int         errs   = 0;
    int         checks = 0;
    logic [7:0] rxq[$];
    int         und_cnt = 0;

    spi_slave_sync #(.BITS(8), .FILL(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxq.push_back(rx_data);
        if (tx_underrun === 1'b1) und_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check that exactly n words arrived since base, and the first is w0.
    task automatic chk_rx(input string tag, input int base, input int n, input logic [7:0] w0);
        chk({tag, "_n"}, 32'(rxq.size() - base), 32'(n));
        if (rxq.size() > base) chk(tag, 32'(rxq[base]), 32'(w0));
    endtask

    task automatic buf_write(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) chk("wr_timeout", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master: ss_n rises together with the final sclk fall.
    task automatic spi_xfer(input int nbits, input logic [15:0] mo, input int half,
                            output logic [15:0] mi);
        mi = '0;
        @(negedge clk);
        ss_n = 1'b0;
        mosi = mo[nbits-1];
        repeat (half > 3 ? half : 3) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk = 1'b1;
            mi   = {mi[14:0], miso};
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if (i == 0) ss_n = 1'b1;
            else        mosi = mo[i-1];
            repeat (half) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] mi;
        int          base;
        int          ub;
        logic [7:0]  t;
        logic [7:0]  m;

        rst_n    = 1'b0;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #23;
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_miso_oe",  32'(miso_oe),  32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single word, buffer loaded
        buf_write(8'hA5);
        chk("t1_full", 32'(tx_ready), 32'd0);
        base = rxq.size(); ub = und_cnt;
        spi_xfer(8, 16'h003C, 4, mi);
        chk("t1_miso", 32'(mi), 32'h00A5);
        chk_rx("t1_rx", base, 1, 8'h3C);
        chk("t1_rx_data", 32'(rx_data), 32'h3C);
        chk("t1_tx_ready", 32'(tx_ready), 32'd1);
        chk("t1_underrun", 32'(und_cnt - ub), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: back-to-back words under one select
        buf_write(8'h11);
        base = rxq.size(); ub = und_cnt;
        fork
            spi_xfer(16, 16'hF00F, 4, mi);
            buf_write(8'h22);
        join
        chk("t2_miso", 32'(mi), 32'h1122);
        chk_rx("t2_rx0", base, 2, 8'hF0);
        if (rxq.size() > base + 1) chk("t2_rx1", 32'(rxq[base+1]), 32'h0F);
        chk("t2_underrun", 32'(und_cnt - ub), 32'd0);

        // 3: empty buffer shifts FILL
        base = rxq.size(); ub = und_cnt;
        spi_xfer(8, 16'h00FF, 4, mi);
        chk("t3_miso", 32'(mi), 32'h0000);
        chk("t3_underrun", 32'(und_cnt - ub), 32'd1);
        chk_rx("t3_rx", base, 1, 8'hFF);

        // 4: aborted partial word, then a full one
        base = rxq.size();
        spi_xfer(5, 16'h0015, 4, mi);
        chk("t4_rx_n", 32'(rxq.size() - base), 32'd0);
        chk("t4_rx_keep", 32'(rx_data), 32'hFF);
        chk("t4_busy", 32'(busy), 32'd0);
        spi_xfer(8, 16'h0081, 4, mi);
        chk("t4_rx_data", 32'(rx_data), 32'h81);

        // 5: asynchronous reset mid-word
        @(negedge clk);
        ss_n = 1'b0;
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        buf_write(8'h5A);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("t5_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",     32'(busy),        32'd0);
        chk("t5_miso_oe",  32'(miso_oe),     32'd0);
        chk("t5_miso",     32'(miso),        32'd0);
        chk("t5_tx_ready", 32'(tx_ready),    32'd1);
        chk("t5_rx_data",  32'(rx_data),     32'd0);
        chk("t5_rx_valid", 32'(rx_valid),    32'd0);
        chk("t5_underrun", 32'(tx_underrun), 32'd0);
        ss_n = 1'b1;
        sclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        buf_write(8'hC3);
        spi_xfer(8, 16'h0096, 4, mi);
        chk("t5_miso_after", 32'(mi), 32'h00C3);
        chk("t5_rx_after", 32'(rx_data), 32'h96);

        // 6: minimum sclk timing, random words
        for (int k = 0; k < 32; k++) begin
            t = 8'($urandom);
            m = 8'($urandom);
            buf_write(t);
            base = rxq.size();
            spi_xfer(8, {8'h00, m}, 3, mi);
            chk("t6_miso", 32'(mi), {24'h0, t});
            chk_rx("t6_rx", base, 1, m);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
